zigzag_buf: RTL
===============

// Module: zigzag_buf
// PURPOSE
//  Downstream of the forward DCT/quantiser. Accepts 64 quantised coefficients per 8x8 block
//  in raster (row-major u,v) order, one per cycle, with no backpressure on the input.
//  Re-emits each block in JPEG zig-zag order to the entropy coder over a valid/ready handshake.
//  Ping-pong double buffer: one bank fills while the other drains.
// PARAMETERS
//  DW      8   coefficient width (bits), stored and emitted unchanged
// PORTS
//  clk         in   1    clock; all state updates on rising edge
//  rst         in   1    asynchronous, active-high reset
//  din         in   DW   quantised coefficient, raster order
//  din_valid   in   1    din valid; no ready, so the source never stalls
//  dout        out  DW   coefficient in zig-zag order
//  dout_valid  out  1    dout valid
//  dout_ready  in   1    sink accepts dout when dout_valid & dout_ready
//  ovf         out  1    sticky: a din sample was dropped because both banks were full
//  dout_last   out  1    [ZZ_LAST_EN only] high with the 64th zig-zag sample of a block
// BEHAVIOUR
//  - Reset: wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, full[1:0]=0, ovf=0.
//    Outputs: dout_valid=0, ovf=0, dout_last=0. dout value is don't-care while dout_valid=0.
//  - Write side, when din_valid:
//    - If !full[wr_bank]: bank[wr_bank][wr_cnt] <= din; wr_cnt++ (6-bit).
//    - When wr_cnt==63 is written: full[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
//    - If full[wr_bank]: the sample is dropped, ovf <= 1 (sticky until reset), wr_cnt holds.
//  - Input gaps: din_valid may drop anywhere inside a block; wr_cnt holds; no timeout.
//  - Read side:
//    - dout_valid = full[rd_bank] (registered state).
//    - dout = bank[rd_bank][ZZ_ORDER[rd_cnt]], a combinational mux from the flop array.
//    - On dout_valid & dout_ready: rd_cnt++.
//    - At rd_cnt==63 accepted: full[rd_bank] <= 0, rd_bank toggles, rd_cnt wraps to 0.
//    - dout_valid low: dout_ready is ignored.
//    - dout_valid high & dout_ready low: dout and dout_valid hold stable.
//  - Latency: the last raster sample written at edge N gives dout_valid=1 in the cycle after
//    edge N. Full throughput: 1 sample/cycle in and out, sustained with dout_ready=1.
//  - Simultaneous events:
//    - Write completing bank A and read finishing bank B in the same cycle: both flag updates
//      take effect; the banks differ by construction.
//    - A bank freed by the read side becomes writable at the next edge. No same-cycle
//      write-through, so a din on that same cycle while the bank is still flagged full is
//      dropped and raises ovf.
//  - Reset mid-operation: all partial blocks are discarded and the FSM returns to the
//    reset state. Bank contents are not cleared; they need no reset.
//  - Per-bank states: EMPTY (full=0, cnt 0) -> FILLING (wr_cnt>0) -> FULL (full=1)
//    -> DRAINING (rd_cnt>0) -> EMPTY.
// CONFIGURATION
//  - ZZ_LAST_EN defined: dout_last port present; dout_last = dout_valid & (rd_cnt==63).
//  - ZZ_LAST_EN undefined: dout_last port and its logic are absent; everything else is identical.
// STRUCTURE
//  - Package jpeg_zz_pkg: localparam ZZ_ORDER[64] (6-bit raster index per zig-zag position,
//    ZZ_ORDER[0..5]=0,1,8,16,9,2 ... ZZ_ORDER[63]=63), BLK_SZ=64, typedef zz_idx_t=logic[5:0].
//  - Sub-module zz_bank: 64xDW flop array with one write port and one read port
//    (write enable/address/data, combinational read address -> data). Instantiated twice.
//    Bank select muxing lives in zigzag_buf.
// TESTING
//  1. Ramp block din=0..63, dout_ready=1
//     -> dout = 0,1,8,16,9,2,3,10,...,63; dout_valid rises 1 cycle after 64th din.
//  2. Two back-to-back ramp blocks (0..63, then 64..127), dout_ready=1
//     -> 128 contiguous outputs in zig-zag order, ovf=0.
//  3. dout_ready toggling 1,0,1,0 during a drain
//     -> each sample held while ready=0; no duplicates or skips; dout_last on ZZ_ORDER[63].
//  4. dout_ready=0, feed 3 full blocks
//     -> first two stored; the 129th din raises ovf=1 and stays high.
//     -> Then ready=1: blocks 1 and 2 emerge intact.
//  5. din_valid with random gaps inside a block
//     -> output identical to test 1; no output until the 64th valid sample.
//  6. Assert rst after 30 samples of a block and during a drain
//     -> dout_valid=0 and ovf=0 next cycle; a fresh ramp afterwards reproduces test 1 exactly.

Source files
------------

// File: rtl/jpeg_zz_pkg.sv
// Shared types and the JPEG zig-zag scan table.
// Each entry maps a zig-zag position to its raster index.
package jpeg_zz_pkg;
  localparam int BLK_SZ = 64;
  typedef logic [5:0] zz_idx_t;
  localparam zz_idx_t ZZ_ORDER [BLK_SZ] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
endpackage

// File: rtl/zigzag_buf_if.sv
// Raster input and zig-zag output bundle of zigzag_buf.
// Optional macro ZZ_LAST_EN adds dout_last.
interface zigzag_buf_if #(
  parameter int DW = 8
);
  logic [DW-1:0] din;
  logic          din_valid;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
`ifdef ZZ_LAST_EN
  logic          dout_last;
  modport master (
    output din, din_valid, dout_ready,
    input  dout, dout_valid, dout_last
  );
  modport slave (
    input  din, din_valid, dout_ready,
    output dout, dout_valid, dout_last
  );
`else
  modport master (
    output din, din_valid, dout_ready,
    input  dout, dout_valid
  );
  modport slave (
    input  din, din_valid, dout_ready,
    output dout, dout_valid
  );
`endif
endinterface

// File: rtl/zigzag_buf_bank.sv
// One 64-entry coefficient bank: one write port, one async read port.
// Contents are not reset; a bank is only read after being filled.
module zz_bank
  import jpeg_zz_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  zz_idx_t       waddr,
  input  logic [DW-1:0] wdata,
  input  zz_idx_t       raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [BLK_SZ];
  logic [DW-1:0] mem_d [BLK_SZ];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/zigzag_buf.sv
// Ping-pong raster-to-zig-zag reorder buffer for 8x8 coefficient blocks.
// Optional macro ZZ_LAST_EN adds dout_last on the final sample of a block.
module zigzag_buf
  import jpeg_zz_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic     clk,
  input  logic     rst,
  zigzag_buf_if.slave zz,
  output logic     ovf
);
  localparam zz_idx_t LAST = zz_idx_t'(BLK_SZ - 1);

  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  zz_idx_t       wr_cnt_q, wr_cnt_d;
  zz_idx_t       rd_cnt_q, rd_cnt_d;
  logic [1:0]    full_q, full_d;
  logic          ovf_q, ovf_d;

  logic          wr_en, wr_last;
  logic          rd_fire, rd_last;
  logic [1:0]    we;
  zz_idx_t       rd_addr;
  logic [DW-1:0] rd_data [2];

  always_comb begin
    wr_en   = zz.din_valid & ~full_q[wr_bank_q];
    wr_last = wr_en & (wr_cnt_q == LAST);
    rd_fire = full_q[rd_bank_q] & zz.dout_ready;
    rd_last = rd_fire & (rd_cnt_q == LAST);

    we            = '0;
    we[wr_bank_q] = wr_en;

    // Completing and finishing banks always differ, so both updates stand.
    full_d = full_q;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
    if (rd_last) full_d[rd_bank_q] = 1'b0;

    wr_cnt_d  = wr_en ? wr_cnt_q + 6'd1 : wr_cnt_q;
    rd_cnt_d  = rd_fire ? rd_cnt_q + 6'd1 : rd_cnt_q;
    wr_bank_d = wr_bank_q ^ wr_last;
    rd_bank_d = rd_bank_q ^ rd_last;
    ovf_d     = ovf_q | (zz.din_valid & full_q[wr_bank_q]);

    rd_addr = ZZ_ORDER[rd_cnt_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      full_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    zz_bank #(.DW(DW)) u_bank (
      .clk   (clk),
      .we    (we[b]),
      .waddr (wr_cnt_q),
      .wdata (zz.din),
      .raddr (rd_addr),
      .rdata (rd_data[b])
    );
  end

  assign zz.dout       = rd_data[rd_bank_q];
  assign zz.dout_valid = full_q[rd_bank_q];
  assign ovf           = ovf_q;
`ifdef ZZ_LAST_EN
  assign zz.dout_last  = full_q[rd_bank_q] & (rd_cnt_q == LAST);
`endif
endmodule
